// File: rtl/apb_sram_slave.sv
// apb_sram_slave: APB completer backed by a word-organised SRAM.
// Byte-lane write strobes, a fixed number of wait states per access,
// and an error response for out-of-range or misaligned addresses.
// Outputs are registered, and the store is cleared by reset.

module apb_sram_slave #(
  parameter int PADDR_SIZE  = 8,
  parameter int PDATA_SIZE  = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [2:0]              PPROT,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR
);

  localparam int NBYTES = PDATA_SIZE / 8;
  localparam int LSB    = $clog2(NBYTES);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int CNT_W  = 4;

  localparam logic [CNT_W-1:0]    WAIT_C        = CNT_W'(WAIT_CYCLES);
  localparam logic                READY_FIRST_C = (WAIT_CYCLES == 0);
  localparam logic [PADDR_SIZE:0] LIMIT_C       = (PADDR_SIZE+1)'(DEPTH * NBYTES);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [CNT_W-1:0]      cnt_r;
  logic [CNT_W-1:0]      cnt_nxt_s;
  logic                  pready_r;
  logic                  pready_nxt_s;
  logic                  pslverr_r;
  logic                  pslverr_nxt_s;
  logic [PDATA_SIZE-1:0] prdata_r;
  logic [PDATA_SIZE-1:0] prdata_nxt_s;
  logic                  wr_en_s;

  logic [PDATA_SIZE-1:0] mem_r [DEPTH];

  logic                  illegal_s;
  logic [IDX_W-1:0]      idx_s;
  logic [PDATA_SIZE-1:0] rd_word_s;
  logic                  unused_pprot_s;

  // Protection attributes carry no meaning for this store.
  assign unused_pprot_s = ^PPROT;

  // Word index and legality of the presented byte address.
  assign idx_s     = PADDR[LSB +: IDX_W];
  assign illegal_s = ({1'b0, PADDR} >= LIMIT_C) ||
                     (PADDR[LSB-1:0] != {LSB{1'b0}});

  // Response data: the stored word for legal reads, zero otherwise.
  assign rd_word_s = (PWRITE || illegal_s) ? {PDATA_SIZE{1'b0}} : mem_r[idx_s];

  // State register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode: setup enters ACCESS; completion or abort returns to IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          state_nxt_s = ST_ACCESS;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!PSEL) begin
          state_nxt_s = ST_IDLE;
        end else if (PENABLE && pready_r) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output/counter decode: next values of the registered response and the write enable.
  always_comb begin
    cnt_nxt_s     = cnt_r;
    pready_nxt_s  = pready_r;
    pslverr_nxt_s = pslverr_r;
    prdata_nxt_s  = prdata_r;
    wr_en_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (PSEL && !PENABLE) begin
          cnt_nxt_s    = WAIT_C;
          pready_nxt_s = READY_FIRST_C;
          if (READY_FIRST_C) begin
            pslverr_nxt_s = illegal_s;
            prdata_nxt_s  = rd_word_s;
          end else begin
            pslverr_nxt_s = 1'b0;
            prdata_nxt_s  = {PDATA_SIZE{1'b0}};
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_ACCESS: begin
        if (!PSEL) begin
          cnt_nxt_s     = {CNT_W{1'b0}};
          pready_nxt_s  = 1'b0;
          pslverr_nxt_s = 1'b0;
          prdata_nxt_s  = {PDATA_SIZE{1'b0}};
        end else if (PENABLE && pready_r) begin
          cnt_nxt_s     = {CNT_W{1'b0}};
          pready_nxt_s  = 1'b0;
          pslverr_nxt_s = 1'b0;
          prdata_nxt_s  = {PDATA_SIZE{1'b0}};
          wr_en_s       = PWRITE && !illegal_s;
        end else if (PENABLE) begin
          cnt_nxt_s = cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            pready_nxt_s  = 1'b1;
            pslverr_nxt_s = illegal_s;
            prdata_nxt_s  = rd_word_s;
          end else begin
            pready_nxt_s = 1'b0;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        cnt_nxt_s     = {CNT_W{1'b0}};
        pready_nxt_s  = 1'b0;
        pslverr_nxt_s = 1'b0;
        prdata_nxt_s  = {PDATA_SIZE{1'b0}};
      end
    endcase
  end

  // Registered response and wait counter.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      cnt_r     <= {CNT_W{1'b0}};
      pready_r  <= 1'b0;
      pslverr_r <= 1'b0;
      prdata_r  <= {PDATA_SIZE{1'b0}};
    end else begin
      cnt_r     <= cnt_nxt_s;
      pready_r  <= pready_nxt_s;
      pslverr_r <= pslverr_nxt_s;
      prdata_r  <= prdata_nxt_s;
    end
  end

  // Storage: cleared on reset, byte-lane merge on a legal write completion.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {PDATA_SIZE{1'b0}};
      end
    end else if (wr_en_s) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (PSTRB[b]) begin
          mem_r[idx_s][8*b +: 8] <= PWDATA[8*b +: 8];
        end
      end
    end
  end

  assign PREADY  = pready_r;
  assign PSLVERR = pslverr_r;
  assign PRDATA  = prdata_r;

endmodule

// File: tb/tb_apb_sram_slave.sv
// Testbench for apb_sram_slave: one instance with two wait states and one with none,
// directed scenarios plus random traffic checked against a word-array model.

module tb_apb_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;

  int tests = 0;
  int fails = 0;
  logic [31:0] model [2][16];
  logic [31:0] rd_obs;

  always #5 clk = ~clk;

  apb_sram_slave #(.PADDR_SIZE(8), .PDATA_SIZE(32), .DEPTH(16), .WAIT_CYCLES(2)) dut_a (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata_a), .PREADY(pready_a), .PSLVERR(pslverr_a)
  );

  apb_sram_slave #(.PADDR_SIZE(8), .PDATA_SIZE(32), .DEPTH(16), .WAIT_CYCLES(0)) dut_b (
    .PCLK(clk), .PRESET(rst), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
    .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
    .PRDATA(prdata_b), .PREADY(pready_b), .PSLVERR(pslverr_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit illegal_f(input logic [7:0] a);
    return (a >= 8'd64) || (a % 4 != 0);
  endfunction

  task automatic clear_models();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        model[d][i] = 32'h0;
  endtask

  // One APB transfer on instance d (0: two wait states, 1: none).
  // abort_at / reset_at name the access cycle in which PSEL drops or PRESET rises (0 = never).
  task automatic xfer(input int d, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                      input logic [3:0] st, input int abort_at, input int reset_at,
                      output logic [31:0] rd_seen);
    int w;
    bit ill;
    logic [31:0] exp_rd;
    time t0;
    w = (d == 0) ? 2 : 0;
    ill = illegal_f(a);
    exp_rd = (wr || ill) ? 32'h0 : model[d][a[5:2]];
    rd_seen = 32'hx;
    t0 = $time;
    psel = 2'b00;
    psel[d] = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
    pprot = 3'($urandom_range(0, 7));
    @(posedge clk); #1;
    penable = 1'b1;
    for (int k = 1; k <= w + 1; k++) begin
      if (k == abort_at) begin
        psel = 2'b00; penable = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", {31'b0, (d == 0) ? pready_a : pready_b}, 32'h0);
        return;
      end
      if (k == reset_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; psel = 2'b00; penable = 1'b0;
        clear_models();
        chk("rst_ready", {31'b0, (d == 0) ? pready_a : pready_b}, 32'h0);
        chk("rst_slverr", {31'b0, (d == 0) ? pslverr_a : pslverr_b}, 32'h0);
        chk("rst_rdata", (d == 0) ? prdata_a : prdata_b, 32'h0);
        return;
      end
      if (k < w + 1) begin
        chk("wait_ready", {31'b0, (d == 0) ? pready_a : pready_b}, 32'h0);
        @(posedge clk); #1;
      end else begin
        rd_seen = (d == 0) ? prdata_a : prdata_b;
        chk("ready", {31'b0, (d == 0) ? pready_a : pready_b}, 32'h1);
        chk("slverr", {31'b0, (d == 0) ? pslverr_a : pslverr_b}, {31'b0, ill});
        chk("rdata", rd_seen, exp_rd);
      end
    end
    @(posedge clk); #1;
    psel = 2'b00; penable = 1'b0;
    if (wr && !ill)
      for (int b = 0; b < 4; b++)
        if (st[b]) model[d][a[5:2]][8*b +: 8] = wd[8*b +: 8];
    chk("ready_clear", {31'b0, (d == 0) ? pready_a : pready_b}, 32'h0);
    chk("latency", 32'((($time - t0) / 10)), 32'(w + 2));
  endtask

  task automatic readback_all(input int d);
    logic [31:0] r;
    for (int i = 0; i < 16; i++) xfer(d, 1'b0, 8'(i * 4), 32'h0, 4'h0, 0, 0, r);
  endtask

  initial begin
    logic [7:0] ra;
    rst = 1'b1; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
    paddr = 8'h0; pwdata = 32'h0; pstrb = 4'h0; pprot = 3'h0;
    clear_models();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready_a", {31'b0, pready_a}, 32'h0);
    chk("reset_slverr_a", {31'b0, pslverr_a}, 32'h0);
    chk("reset_rdata_a", prdata_a, 32'h0);
    chk("reset_ready_b", {31'b0, pready_b}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: read after reset
    xfer(0, 1'b0, 8'h00, 32'h0, 4'h0, 0, 0, rd_obs);
    chk("t1_rdata", rd_obs, 32'h0);

    // 2: full then partial write, then read
    xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 0, 0, rd_obs);
    xfer(0, 1'b1, 8'h04, 32'h11223344, 4'h5, 0, 0, rd_obs);
    xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, 0, 0, rd_obs);
    chk("t2_merge", rd_obs, 32'hDE22BE44);

    // 3: out-of-range write, misaligned read, then full readback
    xfer(0, 1'b1, 8'h40, 32'hA5A5A5A5, 4'hF, 0, 0, rd_obs);
    xfer(0, 1'b0, 8'h06, 32'h0, 4'h0, 0, 0, rd_obs);
    chk("t3_misaligned_rdata", rd_obs, 32'h0);
    readback_all(0);

    // 4: write aborted after one access cycle
    xfer(0, 1'b1, 8'h08, 32'hCAFEF00D, 4'hF, 2, 0, rd_obs);
    xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, 0, 0, rd_obs);
    chk("t4_no_write", rd_obs, 32'h0);

    // 5: zero-wait instance, back-to-back pairs
    for (int n = 0; n < 4; n++) begin
      logic [31:0] v;
      v = $urandom;
      xfer(1, 1'b1, 8'h0C, v, 4'hF, 0, 0, rd_obs);
      xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, 0, 0, rd_obs);
      chk("t5_readback", rd_obs, v);
    end

    // random traffic on both instances
    for (int n = 0; n < 80; n++) begin
      int d;
      d = n % 2;
      if ($urandom_range(0, 3) != 0) ra = 8'($urandom_range(0, 15) * 4);
      else ra = 8'($urandom_range(0, 95));
      xfer(d, 1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom_range(0, 15)), 0, 0, rd_obs);
    end
    readback_all(0);
    readback_all(1);

    // 6: reset during the wait state of a write
    xfer(0, 1'b1, 8'h10, 32'h12345678, 4'hF, 0, 2, rd_obs);
    @(posedge clk); #1;
    xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, 0, 0, rd_obs);
    chk("t6_after_reset", rd_obs, 32'h0);
    readback_all(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/apb_sram_slave.md
Name: apb_sram_slave

Overview:
- Downstream APB completer for the AHB-Lite to APB bridge; consumes the bridge's APB master-side signals.
- Word-organised register/SRAM store with byte-lane write strobes, a parameterised wait-state counter driving PREADY, and PSLVERR on illegal accesses.
- Serves as the bench's APB target and as a reusable peripheral model.

Parameters:
- PADDR_SIZE, 8, APB address width.
- PDATA_SIZE, 32, APB data width (32 or 64); PSTRB width = PDATA_SIZE/8.
- DEPTH, 16, number of data words (power of two, at least 2).
- WAIT_CYCLES, 2, wait states inserted in every access phase (0 to 15).

Ports:
- PCLK  in  1  clock; all state changes on its rising edge.
- PRESET  in  1  synchronous, active-high reset.
- PSEL  in  1  slave select.
- PENABLE  in  1  access-phase indicator.
- PWRITE  in  1  1 = write, 0 = read.
- PADDR  in  PADDR_SIZE  byte address.
- PWDATA  in  PDATA_SIZE  write data.
- PSTRB  in  PDATA_SIZE/8  byte-lane write enables.
- PPROT  in  3  accepted and ignored.
- PRDATA  out  PDATA_SIZE  read data; valid only while PREADY=1.
- PREADY  out  1  transfer completes on the current edge when high in the access phase.
- PSLVERR  out  1  error response; valid only while PREADY=1.

Behaviour:
- Interface decision: one clock, PCLK. Reset PRESET is synchronous and active-high.
- Reset (PRESET=1 at an edge):
  - PREADY, PSLVERR and PRDATA are set to 0.
  - The state machine goes to IDLE and the wait counter to 0.
  - All memory words are cleared to 0.
  - Reset overrides any in-flight transfer; no write commits.
- Address decode:
  - LSB = log2(PDATA_SIZE/8); word index = PADDR[LSB +: log2(DEPTH)].
  - Illegal access: PADDR >= DEPTH*(PDATA_SIZE/8), or PADDR[LSB-1:0] != 0.
- State machine: IDLE and ACCESS.
  - IDLE: when PSEL=1 and PENABLE=0 (setup phase), go to ACCESS. Load cnt = WAIT_CYCLES and set PREADY <= (WAIT_CYCLES==0).
    - If PREADY is being set, also set PSLVERR <= illegal, and PRDATA <= memory word (0 if illegal or a write).
    - PSEL=1 with PENABLE=1 in IDLE is a protocol error: ignore it and stay in IDLE.
  - ACCESS with PSEL=1, PENABLE=1 and PREADY=0: cnt <= cnt-1.
    - When cnt==1, set PREADY <= 1 and load PSLVERR and PRDATA as above.
  - ACCESS with PSEL=1, PENABLE=1 and PREADY=1 (completion edge):
    - If a legal write: for each lane i with PSTRB[i]=1, mem[idx][8i+7:8i] <= PWDATA[8i+7:8i]. Lanes with PSTRB[i]=0 are unchanged.
    - Illegal writes do not modify memory. Reads have no side effect.
    - Clear PREADY, PSLVERR and PRDATA to 0 and return to IDLE.
  - ACCESS with PSEL=0 (aborted transfer): return to IDLE, clear outputs, no write.
- Latency:
  - The access phase lasts exactly WAIT_CYCLES+1 cycles, so a transfer is WAIT_CYCLES+2 cycles from setup to completion.
  - Back-to-back: a new setup phase in the cycle after completion is accepted normally.
- Control and address:
  - Decode and the read word are sampled in the cycle PREADY is set. The master holds PADDR, PWRITE, PWDATA and PSTRB stable throughout the access phase per APB.
  - The write uses PWDATA and PSTRB at the completion edge.
- Outputs PREADY, PSLVERR and PRDATA are registered; there is no combinational path from input to output.
- Reading an address in the same cycle that address is written returns the old data; new data is visible from the next transfer.

Test Plan:
1. Reset, then read address 0x00 with WAIT_CYCLES=2 -> PREADY is high exactly in the 3rd access cycle; PRDATA=0x00000000, PSLVERR=0.
2. Write 0xDEADBEEF to 0x04 with PSTRB=0xF, then write 0x11223344 to 0x04 with PSTRB=0x5, then read 0x04 -> PRDATA=0xDE22BE44, PSLVERR=0.
3. Write to 0x40 (out of range for DEPTH=16) and read 0x06 (misaligned) -> PSLVERR=1 with PREADY on both transfers; the read returns PRDATA=0; memory is unchanged (verify with a full readback of all 16 words).
4. PSEL dropped after 1 access cycle of a write of 0xCAFEF00D to 0x08 -> no PREADY pulse; a following read of 0x08 returns 0; the slave accepts the next setup normally.
5. Build with WAIT_CYCLES=0 and issue back-to-back write/read pairs to 0x0C -> PREADY is high in the first access cycle; each transfer takes 2 cycles; readback matches.
6. PRESET asserted during the wait state of a write of 0x12345678 to 0x10 -> outputs are 0 the next cycle; a read of 0x10 after reset returns 0.
